// File: rtl/array_max_scanner.sv
// Post-run result engine: walks a fixed array of signed words in data memory
// and reports the maximum value and the index where it first occurs.
module array_max_scanner #(
    parameter logic [31:0] BASE_ADDR  = 32'd1000,
    parameter int unsigned LEN        = 20,
    parameter int unsigned WORD_BYTES = 4
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        start,
    output logic [31:0] memAddress,
    output logic        memRead,
    input  logic [31:0] memReadData,
    output logic [31:0] max,
    output logic [31:0] maxIndex,
    output logic        busy,
    output logic        done
);

    localparam int unsigned IDX_W = 16;
    localparam logic [IDX_W-1:0] LAST_IDX = IDX_W'(LEN - 1);
    localparam logic [31:0] STRIDE = 32'(WORD_BYTES);

    typedef enum logic [1:0] {
        IDLE,
        SCAN,
        FINISH
    } state_e;

    state_e             state_q, state_d;
    logic [IDX_W-1:0]   idx_q, idx_d;
    logic [31:0]        max_q, max_d;
    logic [IDX_W-1:0]   max_idx_q, max_idx_d;
    logic               busy_q, busy_d;
    logic               done_q, done_d;

    // Next-state, datapath updates and the combinational memory request.
    always_comb begin
        state_d    = state_q;
        idx_d      = idx_q;
        max_d      = max_q;
        max_idx_d  = max_idx_q;
        busy_d     = 1'b0;
        done_d     = 1'b0;
        memRead    = 1'b0;
        memAddress = 32'd0;

        case (state_q)
            IDLE: begin
                if (start) begin
                    if (LEN > 0) begin
                        state_d = SCAN;
                        idx_d   = '0;
                        busy_d  = 1'b1;
                    end else begin
                        state_d   = FINISH;
                        max_d     = 32'd0;
                        max_idx_d = '0;
                        done_d    = 1'b1;
                    end
                end
            end
            SCAN: begin
                memRead    = 1'b1;
                memAddress = BASE_ADDR + 32'(idx_q) * STRIDE;
                // Strict compare: equal values keep the earlier index.
                if ((idx_q == '0) || ($signed(memReadData) > $signed(max_q))) begin
                    max_d     = memReadData;
                    max_idx_d = idx_q;
                end
                if (idx_q == LAST_IDX) begin
                    state_d = FINISH;
                    done_d  = 1'b1;
                end else begin
                    idx_d  = idx_q + IDX_W'(1);
                    busy_d = 1'b1;
                end
            end
            FINISH: begin
                state_d = IDLE;
            end
            default: begin
                state_d = IDLE;
            end
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q   <= IDLE;
            idx_q     <= '0;
            max_q     <= 32'd0;
            max_idx_q <= '0;
            busy_q    <= 1'b0;
            done_q    <= 1'b0;
        end else begin
            state_q   <= state_d;
            idx_q     <= idx_d;
            max_q     <= max_d;
            max_idx_q <= max_idx_d;
            busy_q    <= busy_d;
            done_q    <= done_d;
        end
    end

    assign max      = max_q;
    assign maxIndex = 32'(max_idx_q);
    assign busy     = busy_q;
    assign done     = done_q;

endmodule

// File: tb/tb_array_max_scanner.sv
// Randomized bench for array_max_scanner: behavioural scan model plus
// hand-computed directed cases, including a LEN = 0 instance.
module tb_array_max_scanner;

    localparam int LEN = 5;

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic        start = 1'b0;
    logic [31:0] mem_addr;
    logic        mem_rd;
    logic [31:0] rdata;
    logic [31:0] dut_max;
    logic [31:0] dut_idx;
    logic        dut_busy;
    logic        dut_done;

    logic        start0 = 1'b0;
    logic [31:0] z_addr;
    logic        z_rd;
    logic [31:0] z_rdata = 32'h1234_5678;
    logic [31:0] z_max;
    logic [31:0] z_idx;
    logic        z_busy;
    logic        z_done;
    logic        z_rd_seen = 1'b0;

    logic [31:0] arr [LEN];

    int n_checks = 0;
    int n_errors = 0;

    // Model state: 0 idle, 1 scanning, 2 finish
    int          phase = 0;
    int          k = 0;
    logic [31:0] exp_max = 32'd0;
    logic [31:0] exp_idx = 32'd0;
    int          done_cnt = 0;
    logic [31:0] addr_q[$];

    array_max_scanner #(.BASE_ADDR(32'd1000), .LEN(LEN), .WORD_BYTES(4)) u_dut (
        .clk(clk), .rst(rst), .start(start),
        .memAddress(mem_addr), .memRead(mem_rd), .memReadData(rdata),
        .max(dut_max), .maxIndex(dut_idx), .busy(dut_busy), .done(dut_done)
    );

    array_max_scanner #(.BASE_ADDR(32'd1000), .LEN(0), .WORD_BYTES(4)) u_dut0 (
        .clk(clk), .rst(rst), .start(start0),
        .memAddress(z_addr), .memRead(z_rd), .memReadData(z_rdata),
        .max(z_max), .maxIndex(z_idx), .busy(z_busy), .done(z_done)
    );

    always #5 clk = ~clk;

    // Combinational data memory holding the array.
    always_comb begin
        rdata = 32'hDEAD_BEEF;
        for (int i = 0; i < LEN; i++)
            if (mem_addr == 32'(1000 + 4 * i)) rdata = arr[i];
    end

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_errors++;
            $display("FAIL %s: got %h expected %h at %0t", nm, act, exp, $time);
        end
    endtask

    // Reference maximum: first occurrence of the largest signed value.
    task automatic ref_max(output logic [31:0] m, output logic [31:0] mi);
        m  = arr[0];
        mi = 32'd0;
        for (int i = 1; i < LEN; i++)
            if ($signed(arr[i]) > $signed(m)) begin
                m  = arr[i];
                mi = 32'(i);
            end
    endtask

    always @(posedge clk) begin
        if (rst) begin
            phase   = 0;
            k       = 0;
            exp_max = 32'd0;
            exp_idx = 32'd0;
        end else begin
            case (phase)
                0: if (start) begin phase = 1; k = 0; end
                1: if (k == LEN - 1) begin phase = 2; ref_max(exp_max, exp_idx); end
                   else k++;
                default: phase = 0;
            endcase
        end
    end

    // Compare DUT against the model every cycle.
    always @(negedge clk) begin
        chk("busy", 32'(dut_busy), 32'(phase == 1));
        chk("done", 32'(dut_done), 32'(phase == 2));
        chk("memRead", 32'(mem_rd), 32'(phase == 1));
        chk("memAddress", mem_addr, (phase == 1) ? 32'(1000 + 4 * k) : 32'd0);
        if (phase != 1) begin
            chk("max", dut_max, exp_max);
            chk("maxIndex", dut_idx, exp_idx);
        end
        if (dut_done) done_cnt++;
        if (mem_rd) addr_q.push_back(mem_addr);
        if (z_rd) z_rd_seen = 1'b1;
    end

    task automatic set_arr(input logic [31:0] a0, a1, a2, a3, a4);
        arr[0] = a0; arr[1] = a1; arr[2] = a2; arr[3] = a3; arr[4] = a4;
    endtask

    // Pulse start and return the number of cycles until done is seen.
    task automatic scan_wait(output int lat);
        @(negedge clk) start = 1'b1;
        @(negedge clk) start = 1'b0;
        lat = 1;
        while (!dut_done && lat < 40) begin
            @(negedge clk);
            lat++;
        end
    endtask

    task automatic wait_idle();
        int n = 0;
        while (phase != 0 && n < 40) begin
            @(negedge clk);
            n++;
        end
        chk("idle_timeout", 32'(n < 40), 32'd1);
    endtask

    initial begin
        int lat;
        int c0;
        set_arr(32'd0, 32'd0, 32'd0, 32'd0, 32'd0);

        // Reset held with start high.
        start = 1'b1;
        repeat (3) begin
            @(negedge clk);
            chk("rst_busy", 32'(dut_busy), 32'd0);
            chk("rst_max", dut_max, 32'd0);
            chk("rst_memRead", 32'(mem_rd), 32'd0);
        end
        @(negedge clk) begin rst = 1'b0; start = 1'b0; end
        repeat (3) @(negedge clk);
        chk("post_rst_busy", 32'(dut_busy), 32'd0);

        // Basic scan.
        set_arr(32'd3, 32'd9, -32'sd2, 32'd7, 32'd1);
        addr_q.delete();
        scan_wait(lat);
        chk("basic_latency", 32'(lat), 32'd6);
        chk("basic_max", dut_max, 32'd9);
        chk("basic_idx", dut_idx, 32'd1);
        chk("basic_naddr", 32'(addr_q.size()), 32'd5);
        chk("basic_addr0", addr_q[0], 32'd1000);
        chk("basic_addr4", addr_q[4], 32'd1016);
        wait_idle();

        // Signed values with ties.
        set_arr(-32'sd5, -32'sd1, -32'sd1, -32'sd8, -32'sd9);
        scan_wait(lat);
        chk("tie_max", dut_max, 32'hFFFF_FFFF);
        chk("tie_idx", dut_idx, 32'd1);
        wait_idle();

        // Extremes.
        set_arr(32'h7FFF_FFFF, 32'h8000_0000, 32'h8000_0000, 32'h8000_0000, 32'h7FFF_FFFF);
        scan_wait(lat);
        chk("ext_max", dut_max, 32'h7FFF_FFFF);
        chk("ext_idx", dut_idx, 32'd0);
        wait_idle();

        // Start pulses while busy are ignored.
        set_arr(32'd4, 32'd2, 32'd8, 32'd8, 32'd1);
        c0 = done_cnt;
        @(negedge clk) start = 1'b1;
        repeat (4) @(negedge clk) start = ~start;
        @(negedge clk) start = 1'b0;
        repeat (4) @(negedge clk);
        chk("busy_start_dones", 32'(done_cnt - c0), 32'd1);
        chk("busy_start_max", dut_max, 32'd8);
        chk("busy_start_idx", dut_idx, 32'd2);
        wait_idle();
        set_arr(32'd4, 32'd2, 32'd8, 32'd8, 32'd11);
        scan_wait(lat);
        chk("rescan_max", dut_max, 32'd11);
        chk("rescan_idx", dut_idx, 32'd4);
        wait_idle();

        // Reset in the third scan cycle.
        c0 = done_cnt;
        @(negedge clk) start = 1'b1;
        @(negedge clk) start = 1'b0;
        @(negedge clk);
        @(negedge clk) rst = 1'b1;
        @(negedge clk) begin
            chk("midrst_busy", 32'(dut_busy), 32'd0);
            chk("midrst_max", dut_max, 32'd0);
            chk("midrst_memRead", 32'(mem_rd), 32'd0);
            rst = 1'b0;
        end
        repeat (8) @(negedge clk);
        chk("midrst_nodone", 32'(done_cnt - c0), 32'd0);
        set_arr(32'd1, 32'd2, 32'd3, 32'd4, 32'd5);
        scan_wait(lat);
        chk("after_rst_latency", 32'(lat), 32'd6);
        chk("after_rst_max", dut_max, 32'd5);
        wait_idle();

        // LEN = 0 instance.
        @(negedge clk) start0 = 1'b1;
        @(negedge clk) begin
            start0 = 1'b0;
            chk("len0_done", 32'(z_done), 32'd1);
            chk("len0_busy", 32'(z_busy), 32'd0);
            chk("len0_max", z_max, 32'd0);
            chk("len0_idx", z_idx, 32'd0);
        end
        @(negedge clk) chk("len0_done_off", 32'(z_done), 32'd0);

        // Randomized scans with stray starts and occasional resets.
        for (int it = 0; it < 60; it++) begin
            wait_idle();
            for (int i = 0; i < LEN; i++) begin
                case ($urandom_range(0, 2))
                    0: arr[i] = $urandom;
                    1: arr[i] = 32'($signed($urandom_range(0, 3)) - 2);
                    default: arr[i] = ($urandom_range(0, 1) != 0) ? 32'h7FFF_FFFF : 32'h8000_0000;
                endcase
            end
            for (int c = 0; c < 12; c++) begin
                @(negedge clk);
                start = ($urandom_range(0, 2) == 0);
                rst   = ($urandom_range(0, 40) == 0);
            end
            @(negedge clk) begin start = 1'b0; rst = 1'b0; end
        end
        wait_idle();
        repeat (2) @(negedge clk);

        chk("len0_no_memread", 32'(z_rd_seen), 32'd0);
        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

endmodule

// File: doc/array_max_scanner.md
Name: array_max_scanner

Overview:
- Post-run result engine on the data-memory read side, alongside the pipeline's data port.
- On a start pulse, it walks a fixed array of signed 32-bit words in data memory and reports the maximum value and its element index.
- Feeds the result registers the testbench and debug logic check after a program finishes.
- FSM plus address counter; memory access is one word per cycle through a read-only port.

Parameters:
- BASE_ADDR, 1000, byte address of array element 0 (word aligned)
- LEN, 20, number of elements scanned; legal range 0..2^16-1
- WORD_BYTES, 4, byte stride between elements

Ports:
- clk  input  1  system clock, rising edge
- rst  input  1  synchronous, active-high reset
- start  input  1  one-cycle request to begin a scan
- memAddress  output  32  byte address presented to data memory
- memRead  output  1  read strobe to data memory
- memReadData  input  32  read data; combinational, valid in the same cycle as memAddress/memRead
- max  output  32  signed maximum found by the last completed scan
- maxIndex  output  32  element index (0-based) of max
- busy  output  1  high while a scan is in progress
- done  output  1  one-cycle pulse when a scan completes

Behaviour:
- Reset:
  - Synchronous; takes priority over all other inputs.
  - State goes to IDLE; index counter = 0.
  - Outputs: max = 0, maxIndex = 0, busy = 0, done = 0, memRead = 0, memAddress = 0.
  - Reset mid-scan aborts the scan; no done pulse is produced.
- States: IDLE, SCAN, FINISH.
- IDLE:
  - memRead = 0, memAddress = 0.
  - start = 1 at a clock edge with LEN > 0: go to SCAN, idx <= 0, busy <= 1.
  - start = 1 with LEN = 0: go to FINISH, max <= 0, maxIndex <= 0.
- SCAN:
  - memRead = 1; memAddress = BASE_ADDR + idx*WORD_BYTES, computed combinationally from the registered idx, 32-bit wrap.
  - At each edge: if idx == 0, or memReadData > max (signed two's-complement compare), then max <= memReadData and maxIndex <= idx.
  - Ties do not update, so the lowest index of equal maxima wins.
  - If idx == LEN-1, go to FINISH; otherwise idx <= idx+1.
- FINISH:
  - busy = 0, done = 1 for exactly this one cycle.
  - Next edge: return to IDLE.
- max and maxIndex hold their values from the end of a scan until the next start is accepted. They are not cleared at start; element 0 unconditionally overwrites them.
- busy is asserted in SCAN only and is registered (goes high the cycle after start is sampled).
- start is ignored in SCAN and FINISH. No queuing.
- Latency: start sampled at edge E; SCAN occupies cycles E+1 .. E+LEN; done is high during cycle E+LEN+1. Total LEN+1 cycles from start to done.
- Memory writes are not issued; the block never drives write enables. The system must not write the array during a scan; results are then undefined, but the FSM still terminates.
- maxIndex is zero-extended from the internal counter width to 32 bits.

Test Plan:
- Reset check: hold rst for 3 cycles with start = 1 -> all outputs 0, busy never rises. Release rst -> FSM remains in IDLE until the next start.
- Basic scan: LEN = 5, BASE_ADDR = 1000, words {3, 9, -2, 7, 1}; pulse start -> memAddress sequence 1000, 1004, 1008, 1012, 1016 with memRead = 1. done pulses exactly 6 cycles after start, with max = 9 and maxIndex = 1.
- Signed values and ties: words {-5, -1, -1, -8}, LEN = 4 -> max = 0xFFFFFFFF (-1), maxIndex = 1. Words {0x7FFFFFFF, 0x80000000} -> max = 0x7FFFFFFF, maxIndex = 0.
- Busy-time start: repeated start pulses during SCAN -> ignored; exactly one done pulse. Results unchanged, and a subsequent start rescans correctly.
- Reset mid-scan: assert rst in the 3rd SCAN cycle -> next cycle busy = 0, max = 0, memRead = 0, and no done pulse. A fresh start then completes normally.
- LEN = 0 build: pulse start -> done high at the 2nd edge after start, max = 0, maxIndex = 0, memRead never asserted.
